// File: rtl/sao_eo_class_pipe.sv
// SAO edge-offset classifier: picks the two EO neighbours of every inner pixel of a
// (WIN_H+2)x(WIN_W+2) window, masks picture/slice edges, and categorises in a 2-stage pipe.
module sao_eo_class_pipe #(
  parameter int WIN_W     = 2,
  parameter int WIN_H     = 2,
  parameter int BIT_DEPTH = 8,
  parameter int N_PIX     = WIN_W * WIN_H
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [(WIN_H+2)*(WIN_W+2)*BIT_DEPTH-1:0]  rec_in,
  input  logic [1:0]                                eo_type,
  input  logic [3:0]                                avail,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [N_PIX*BIT_DEPTH-1:0]                cur_out,
  output logic [N_PIX*BIT_DEPTH-1:0]                n_rec_l,
  output logic [N_PIX*BIT_DEPTH-1:0]                n_rec_r,
  output logic [N_PIX*3-1:0]                        edge_cat,
  output logic [N_PIX-1:0]                          pix_mask
);

  localparam int COLS = WIN_W + 2;
  localparam int BD   = BIT_DEPTH;

  // sign(c-a)+sign(c-b) mapped onto the HEVC edge categories 0..4
  function automatic logic [2:0] eo_cat(input logic [BD-1:0] c,
                                        input logic [BD-1:0] a,
                                        input logic [BD-1:0] b);
    logic signed [2:0] s;
    s = 3'sd0;
    if (c > a)      s = s + 3'sd1;
    else if (c < a) s = s - 3'sd1;
    if (c > b)      s = s + 3'sd1;
    else if (c < b) s = s - 3'sd1;
    case (s)
      3'sb110: eo_cat = 3'd1;
      3'sb111: eo_cat = 3'd2;
      3'sb001: eo_cat = 3'd3;
      3'sb010: eo_cat = 3'd4;
      default: eo_cat = 3'd0;
    endcase
  endfunction

  logic                    s1_valid, s2_valid;
  logic                    s1_adv, s2_adv, accept;
  logic [N_PIX*BD-1:0]     sel_cur, sel_l, sel_r;
  logic [N_PIX-1:0]        sel_mask;
  logic [N_PIX*BD-1:0]     s1_cur, s1_l, s1_r;
  logic [N_PIX-1:0]        s1_mask;
  logic [N_PIX*3-1:0]      s1_cat;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  genvar i, j;
  generate
    for (i = 0; i < WIN_H; i++) begin : g_row
      for (j = 0; j < WIN_W; j++) begin : g_col
        localparam int  P     = i * WIN_W + j;
        localparam int  C     = (i + 1) * COLS + (j + 1);
        localparam bit  AT_L  = (j == 0);
        localparam bit  AT_R  = (j == WIN_W - 1);
        localparam bit  AT_T  = (i == 0);
        localparam bit  AT_B  = (i == WIN_H - 1);

        logic [BD-1:0] smp_nw, smp_n, smp_ne, smp_w, smp_e, smp_sw, smp_s, smp_se;
        logic [BD-1:0] l_smp, r_smp;
        logic          na_w, na_e, na_n, na_s, l_ok, r_ok;

        assign smp_nw = rec_in[(C - COLS - 1) * BD +: BD];
        assign smp_n  = rec_in[(C - COLS)     * BD +: BD];
        assign smp_ne = rec_in[(C - COLS + 1) * BD +: BD];
        assign smp_w  = rec_in[(C - 1)        * BD +: BD];
        assign smp_e  = rec_in[(C + 1)        * BD +: BD];
        assign smp_sw = rec_in[(C + COLS - 1) * BD +: BD];
        assign smp_s  = rec_in[(C + COLS)     * BD +: BD];
        assign smp_se = rec_in[(C + COLS + 1) * BD +: BD];

        // a diagonal neighbour is lost if either of its row or column crosses a missing edge
        assign na_w = AT_L && !avail[0];
        assign na_e = AT_R && !avail[1];
        assign na_n = AT_T && !avail[2];
        assign na_s = AT_B && !avail[3];

        always_comb begin
          l_smp = smp_w;
          r_smp = smp_e;
          l_ok  = !na_w;
          r_ok  = !na_e;
          case (eo_type)
            2'd1: begin
              l_smp = smp_n;  r_smp = smp_s;
              l_ok  = !na_n;  r_ok  = !na_s;
            end
            2'd2: begin
              l_smp = smp_nw; r_smp = smp_se;
              l_ok  = !(na_n || na_w);
              r_ok  = !(na_s || na_e);
            end
            2'd3: begin
              l_smp = smp_sw; r_smp = smp_ne;
              l_ok  = !(na_s || na_w);
              r_ok  = !(na_n || na_e);
            end
            default: ;
          endcase
        end

        assign sel_cur[P*BD +: BD] = rec_in[C*BD +: BD];
        assign sel_l[P*BD +: BD]   = l_smp;
        assign sel_r[P*BD +: BD]   = r_smp;
        assign sel_mask[P]         = l_ok && r_ok;

        assign s1_cat[P*3 +: 3] = s1_mask[P] ?
            eo_cat(s1_cur[P*BD +: BD], s1_l[P*BD +: BD], s1_r[P*BD +: BD]) : 3'd0;
      end
    end
  endgenerate

  // Stage 1: neighbour selection and mask, captured with the eo_type/avail of the beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cur   <= '0;
      s1_l     <= '0;
      s1_r     <= '0;
      s1_mask  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_cur  <= sel_cur;
        s1_l    <= sel_l;
        s1_r    <= sel_r;
        s1_mask <= sel_mask;
      end
    end
  end

  // Stage 2: category registers drive the outputs directly and hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      cur_out  <= '0;
      n_rec_l  <= '0;
      n_rec_r  <= '0;
      edge_cat <= '0;
      pix_mask <= '0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) begin
        cur_out  <= s1_cur;
        n_rec_l  <= s1_l;
        n_rec_r  <= s1_r;
        edge_cat <= s1_cat;
        pix_mask <= s1_mask;
      end
    end
  end

endmodule

// File: tb/tb_sao_eo_class_pipe.sv
// Self-checking bench for sao_eo_class_pipe: hand vectors, corner sequences and a
// randomized scoreboard against a direct arithmetic model of the EO classification.
module tb_sao_eo_class_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance (2x2, 8-bit)
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [127:0] a_rec;
  logic [1:0]   a_eo;
  logic [3:0]   a_avail;
  logic [31:0]  a_cur, a_l, a_r;
  logic [11:0]  a_cat;
  logic [3:0]   a_mask;

  // wide instance (4x2, 10-bit)
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [239:0] b_rec;
  logic [1:0]   b_eo;
  logic [3:0]   b_avail;
  logic [79:0]  b_cur, b_l, b_r;
  logic [23:0]  b_cat;
  logic [7:0]   b_mask;

  sao_eo_class_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rec_in(a_rec), .eo_type(a_eo), .avail(a_avail),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .cur_out(a_cur), .n_rec_l(a_l), .n_rec_r(a_r), .edge_cat(a_cat), .pix_mask(a_mask)
  );

  sao_eo_class_pipe #(.WIN_W(4), .WIN_H(2), .BIT_DEPTH(10)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rec_in(b_rec), .eo_type(b_eo), .avail(b_avail),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .cur_out(b_cur), .n_rec_l(b_l), .n_rec_r(b_r), .edge_cat(b_cat), .pix_mask(b_mask)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  function automatic bit nb_ok(input int dr, input int dc, input int i, input int j,
                               input int w, input int h, input int av);
    if (dc == -1 && j == 0     && ((av >> 0) & 1) == 0) return 1'b0;
    if (dc ==  1 && j == w - 1 && ((av >> 1) & 1) == 0) return 1'b0;
    if (dr == -1 && i == 0     && ((av >> 2) & 1) == 0) return 1'b0;
    if (dr ==  1 && i == h - 1 && ((av >> 3) & 1) == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_win(input int win[0:23], input int w, input int h,
                                    input int eo, input int av,
                                    output int cur[0:7], output int l[0:7], output int r[0:7],
                                    output int cat[0:7], output int m[0:7]);
    int ldr, ldc, rdr, rdc, p, ctr, s;
    int catmap[0:4];
    bit okl, okr;
    catmap = '{1, 2, 0, 3, 4};
    case (eo)
      0:       begin ldr =  0; ldc = -1; rdr =  0; rdc =  1; end
      1:       begin ldr = -1; ldc =  0; rdr =  1; rdc =  0; end
      2:       begin ldr = -1; ldc = -1; rdr =  1; rdc =  1; end
      default: begin ldr =  1; ldc = -1; rdr = -1; rdc =  1; end
    endcase
    for (int k = 0; k < 8; k++) begin
      cur[k] = 0; l[k] = 0; r[k] = 0; cat[k] = 0; m[k] = 0;
    end
    for (int i = 0; i < h; i++) begin
      for (int j = 0; j < w; j++) begin
        p      = i * w + j;
        ctr    = (i + 1) * (w + 2) + (j + 1);
        cur[p] = win[ctr];
        l[p]   = win[ctr + ldr * (w + 2) + ldc];
        r[p]   = win[ctr + rdr * (w + 2) + rdc];
        okl    = nb_ok(ldr, ldc, i, j, w, h, av);
        okr    = nb_ok(rdr, rdc, i, j, w, h, av);
        m[p]   = (okl && okr) ? 1 : 0;
        s      = sgn(cur[p] - l[p]) + sgn(cur[p] - r[p]);
        cat[p] = m[p] ? catmap[s + 2] : 0;
      end
    end
  endfunction

  function automatic logic [255:0] pack8(input int v[0:7], input int n, input int w);
    logic [255:0] o;
    o = '0;
    for (int k = 0; k < n; k++) o = o | (256'(v[k]) << (k * w));
    return o;
  endfunction

  function automatic logic [255:0] pack4(input int v[0:3], input int w);
    logic [255:0] o;
    o = '0;
    for (int k = 0; k < 4; k++) o = o | (256'(v[k]) << (k * w));
    return o;
  endfunction

  typedef struct {
    logic [255:0] cur, l, r, cat, mask;
  } exp_t;

  function automatic exp_t exp_a(input int win[0:23], input int eo, input int av);
    int c[0:7], l[0:7], r[0:7], k[0:7], m[0:7];
    exp_t e;
    model_win(win, 2, 2, eo, av, c, l, r, k, m);
    e.cur  = pack8(c, 4, 8);
    e.l    = pack8(l, 4, 8);
    e.r    = pack8(r, 4, 8);
    e.cat  = pack8(k, 4, 3);
    e.mask = pack8(m, 4, 1);
    return e;
  endfunction

  // ---------------- drivers ----------------
  int a_win[0:23];
  int a_eo_i, a_av_i;
  int tw[0:23];

  task automatic applyStimulus(input int win[0:23], input int eo, input int av);
    a_win  = win;
    a_eo_i = eo;
    a_av_i = av;
    for (int k = 0; k < 16; k++) a_rec[k*8 +: 8] = 8'(win[k]);
    a_eo       = 2'(eo);
    a_avail    = 4'(av);
    a_in_valid = 1'b1;
  endtask

  task automatic applyStimulusB(input int win[0:23], input int eo, input int av);
    for (int k = 0; k < 24; k++) b_rec[k*10 +: 10] = 10'(win[k]);
    b_eo       = 2'(eo);
    b_avail    = 4'(av);
    b_in_valid = 1'b1;
  endtask

  // ---------------- scoreboard monitor (instance A) ----------------
  exp_t         sbq[$];
  bit           sb_en = 1'b0;
  bit           held = 1'b0;
  bit           saw_block = 1'b0;
  logic [255:0] held_val;
  int           acc_cnt = 0;
  int           pop_cnt = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_en) begin
      if (held)
        checkOutput("stall_hold", 256'({a_out_valid, a_cur, a_l, a_r, a_cat, a_mask}), held_val);
      held     = a_out_valid && !a_out_ready;
      held_val = 256'({a_out_valid, a_cur, a_l, a_r, a_cat, a_mask});
      if (a_out_valid && a_out_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL sb_unexpected: got an output beat, expected none pending");
        end else begin
          e = sbq.pop_front();
          pop_cnt++;
          checkOutput("sb_cur",  256'(a_cur),  e.cur);
          checkOutput("sb_l",    256'(a_l),    e.l);
          checkOutput("sb_r",    256'(a_r),    e.r);
          checkOutput("sb_cat",  256'(a_cat),  e.cat);
          checkOutput("sb_mask", 256'(a_mask), e.mask);
        end
      end
      if (a_in_valid && a_in_ready) begin
        sbq.push_back(exp_a(a_win, a_eo_i, a_av_i));
        acc_cnt++;
      end
      if (!a_in_ready) saw_block = 1'b1;
    end
  end

  // ---------------- hand vectors ----------------
  typedef struct {
    int eo;
    int av;
    int win[0:15];
    int cur[0:3];
    int l[0:3];
    int r[0:3];
    int cat[0:3];
    int mask;
  } vec_t;

  vec_t tbl[9];
  int   mc[0:7], ml[0:7], mr[0:7], mk[0:7], mm[0:7];
  int   bp_acc0, bp_pop0, bp_cyc, bp_k;
  exp_t ex;

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_rec = '0; a_eo = 2'd0; a_avail = 4'hF;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_rec = '0; b_eo = 2'd0; b_avail = 4'hF;
    a_eo_i = 0; a_av_i = 15;
    for (int k = 0; k < 24; k++) begin a_win[k] = 0; tw[k] = 0; end

    tbl[0] = '{eo:0, av:15, win:'{0,0,0,0, 10,20,30,40, 50,50,50,50, 0,0,0,0},
               cur:'{20,30,50,50}, l:'{10,20,50,50}, r:'{30,40,50,50}, cat:'{0,0,0,0}, mask:15};
    tbl[1] = '{eo:0, av:15, win:'{0,0,0,0, 30,10,30,0, 50,50,50,50, 0,0,0,0},
               cur:'{10,30,50,50}, l:'{30,10,50,50}, r:'{30,0,50,50}, cat:'{1,4,0,0}, mask:15};
    tbl[2] = '{eo:1, av:11, win:'{1,2,3,4, 5,6,7,8, 9,9,1,9, 0,9,9,9},
               cur:'{6,7,9,1}, l:'{2,3,6,7}, r:'{9,1,9,9}, cat:'{0,0,3,1}, mask:12};
    tbl[3] = '{eo:2, av:15, win:'{0,4,8,12, 16,20,24,28, 32,36,40,44, 48,52,56,60},
               cur:'{20,24,36,40}, l:'{0,4,16,20}, r:'{40,44,56,60}, cat:'{0,0,0,0}, mask:15};
    tbl[4] = '{eo:3, av:15, win:'{0,4,8,12, 16,20,24,28, 32,36,40,44, 48,52,56,60},
               cur:'{20,24,36,40}, l:'{32,36,48,52}, r:'{8,12,24,28}, cat:'{0,0,0,0}, mask:15};
    tbl[5] = '{eo:0, av:15, win:'{100,100,100,100, 100,0,100,100, 100,100,100,100, 100,100,100,100},
               cur:'{0,100,100,100}, l:'{100,0,100,100}, r:'{100,100,100,100}, cat:'{1,3,0,0}, mask:15};
    tbl[6] = '{eo:1, av:15, win:'{100,100,100,100, 100,0,100,100, 100,100,100,100, 100,100,100,100},
               cur:'{0,100,100,100}, l:'{100,100,0,100}, r:'{100,100,100,100}, cat:'{1,0,3,0}, mask:15};
    tbl[7] = '{eo:2, av:15, win:'{100,100,100,100, 100,0,100,100, 100,100,100,100, 100,100,100,100},
               cur:'{0,100,100,100}, l:'{100,100,100,0}, r:'{100,100,100,100}, cat:'{1,0,0,3}, mask:15};
    tbl[8] = '{eo:3, av:15, win:'{100,100,100,100, 100,0,100,100, 100,100,100,100, 100,100,100,100},
               cur:'{0,100,100,100}, l:'{100,100,100,100}, r:'{100,100,100,100}, cat:'{1,0,0,0}, mask:15};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_a_out_valid", 256'(a_out_valid), 256'(0));
    checkOutput("rst_a_in_ready",  256'(a_in_ready),  256'(1));
    checkOutput("rst_a_data", 256'({a_cur, a_l, a_r, a_cat, a_mask}), 256'(0));
    checkOutput("rst_b_out_valid", 256'(b_out_valid), 256'(0));
    checkOutput("rst_b_in_ready",  256'(b_in_ready),  256'(1));
    @(posedge clk); #1 rst = 1'b0;

    // table vectors, one beat at a time with an exact latency check
    for (int t = 0; t < 9; t++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 24; k++) tw[k] = (k < 16) ? tbl[t].win[k] : 0;
      a_out_ready = 1'b1;
      applyStimulus(tw, tbl[t].eo, tbl[t].av);
      @(posedge clk); #1 a_in_valid = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_early", t), 256'(a_out_valid), 256'(0));
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", t), 256'(a_out_valid), 256'(1));
      checkOutput($sformatf("vec%0d_cur", t),   256'(a_cur),  pack4(tbl[t].cur, 8));
      checkOutput($sformatf("vec%0d_l", t),     256'(a_l),    pack4(tbl[t].l, 8));
      checkOutput($sformatf("vec%0d_r", t),     256'(a_r),    pack4(tbl[t].r, 8));
      checkOutput($sformatf("vec%0d_cat", t),   256'(a_cat),  pack4(tbl[t].cat, 3));
      checkOutput($sformatf("vec%0d_mask", t),  256'(a_mask), 256'(tbl[t].mask));
    end
    @(posedge clk); @(posedge clk);

    // randomized traffic with random back-pressure
    held  = 1'b0;
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 24; k++)
        tw[k] = (cyc % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3)) * 64;
      applyStimulus(tw, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_queue_empty", 256'(sbq.size()), 256'(0));
    checkOutput("drain_out_valid",   256'(a_out_valid), 256'(0));

    // six back-to-back beats with the consumer stalled for cycles 3..6
    bp_acc0   = acc_cnt;
    bp_pop0   = pop_cnt;
    bp_cyc    = 0;
    saw_block = 1'b0;
    while ((pop_cnt - bp_pop0) < 6 && bp_cyc < 40) begin
      @(posedge clk); #1;
      bp_cyc++;
      a_out_ready = !(bp_cyc >= 3 && bp_cyc <= 6);
      bp_k = acc_cnt - bp_acc0;
      if (bp_k < 6) begin
        for (int x = 0; x < 24; x++) tw[x] = (bp_k * 37 + x * 11 + x * x) % 256;
        applyStimulus(tw, bp_k % 4, 15);
      end else begin
        a_in_valid = 1'b0;
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_accepted",     256'(acc_cnt - bp_acc0), 256'(6));
    checkOutput("bp_emerged",      256'(pop_cnt - bp_pop0), 256'(6));
    checkOutput("bp_in_ready_low", 256'(saw_block), 256'(1));
    checkOutput("bp_queue_empty",  256'(sbq.size()), 256'(0));
    sb_en = 1'b0;
    held  = 1'b0;

    // asynchronous reset while both stages are full and stalled
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    for (int k = 0; k < 24; k++) tw[k] = k * 9;
    applyStimulus(tw, 0, 15);
    @(posedge clk); #1;
    for (int k = 0; k < 24; k++) tw[k] = 200 - k * 5;
    applyStimulus(tw, 1, 15);
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("full_out_valid", 256'(a_out_valid), 256'(1));
    checkOutput("full_in_ready",  256'(a_in_ready),  256'(0));
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 256'(a_out_valid), 256'(0));
    checkOutput("midrst_in_ready",  256'(a_in_ready),  256'(1));
    checkOutput("midrst_data", 256'({a_cur, a_l, a_r, a_cat, a_mask}), 256'(0));
    @(posedge clk); #1 rst = 1'b0;
    a_out_ready = 1'b1;
    for (int k = 0; k < 24; k++) tw[k] = (k < 16) ? tbl[5].win[k] : 0;
    applyStimulus(tw, 0, 15);
    ex = exp_a(tw, 0, 15);
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("postrst_early", 256'(a_out_valid), 256'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("postrst_valid", 256'(a_out_valid), 256'(1));
    checkOutput("postrst_cur",   256'(a_cur), ex.cur);
    checkOutput("postrst_cat",   256'(a_cat), ex.cat);
    @(posedge clk); #1;

    // wide instance: right edge missing, full-scale extremes
    for (int k = 0; k < 24; k++) tw[k] = 512;
    tw[7] = 1023; tw[6] = 0; tw[8] = 0;
    tw[14] = 0; tw[13] = 1023; tw[15] = 1023;
    applyStimulusB(tw, 0, 4'b1101);
    model_win(tw, 4, 2, 0, 4'b1101, mc, ml, mr, mk, mm);
    @(posedge clk); #1 b_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("wide_valid",   256'(b_out_valid), 256'(1));
    checkOutput("wide_mask",    256'(b_mask), 256'(8'h77));
    checkOutput("wide_cat_p0",  256'(b_cat[2:0]),   256'(4));
    checkOutput("wide_cat_p5",  256'(b_cat[17:15]), 256'(1));
    checkOutput("wide_cat_p3",  256'(b_cat[11:9]),  256'(0));
    checkOutput("wide_cat_all", 256'(b_cat), pack8(mk, 8, 3));

    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 24; k++) begin
        case ($urandom_range(0, 3))
          0:       tw[k] = 0;
          1:       tw[k] = 1023;
          2:       tw[k] = 512;
          default: tw[k] = int'($urandom_range(0, 1023));
        endcase
      end
      bp_k = int'($urandom_range(0, 3));
      bp_cyc = int'($urandom_range(0, 15));
      applyStimulusB(tw, bp_k, bp_cyc);
      model_win(tw, 4, 2, bp_k, bp_cyc, mc, ml, mr, mk, mm);
      @(posedge clk); #1 b_in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("wide%0d_valid", n), 256'(b_out_valid), 256'(1));
      checkOutput($sformatf("wide%0d_cur", n),   256'(b_cur),  pack8(mc, 8, 10));
      checkOutput($sformatf("wide%0d_l", n),     256'(b_l),    pack8(ml, 8, 10));
      checkOutput($sformatf("wide%0d_r", n),     256'(b_r),    pack8(mr, 8, 10));
      checkOutput($sformatf("wide%0d_cat", n),   256'(b_cat),  pack8(mk, 8, 3));
      checkOutput($sformatf("wide%0d_mask", n),  256'(b_mask), pack8(mm, 8, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sao_eo_class_pipe.md
Name: sao_eo_class_pipe

Overview:
Parametrised successor to the SAO statistics neighbour-matching stage. It takes a (WIN_H+2)x(WIN_W+2) reconstructed-sample window, selects the two edge-offset neighbours of every inner pixel for a per-beat EO class, and masks neighbours that fall outside the picture or slice. It computes the HEVC EO edge category per pixel and delivers results through a 2-stage valid/ready pipeline to the SAO statistics accumulators.

Parameters:
WIN_W, 2, inner window width in pixels (>=1)
WIN_H, 2, inner window height in pixels (>=1)
BIT_DEPTH, 8, sample width
N_PIX, WIN_W*WIN_H, derived; pixels per beat; do not override

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
rec_in  in  (WIN_H+2)*(WIN_W+2)*BIT_DEPTH  window, sample (r,c) at index r*(WIN_W+2)+c, LSB-first
eo_type  in  2  0=EO_0, 1=EO_90, 2=EO_135, 3=EO_45
avail  in  4  neighbour availability: [0]=left, [1]=right, [2]=top, [3]=bottom
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
cur_out  out  N_PIX*BIT_DEPTH  centre samples, pixel p=i*WIN_W+j is rec (i+1,j+1)
n_rec_l  out  N_PIX*BIT_DEPTH  first neighbour per pixel
n_rec_r  out  N_PIX*BIT_DEPTH  second neighbour per pixel
edge_cat  out  N_PIX*3  EO category 0..4 per pixel
pix_mask  out  N_PIX  1 = both neighbours available

Behaviour:
- Neighbour offsets (dr,dc) relative to centre (i+1,j+1). l/r: EO_0 (0,-1)/(0,+1); EO_90 (-1,0)/(+1,0); EO_135 (-1,-1)/(+1,+1); EO_45 (+1,-1)/(-1,+1).
- Unavailability: a neighbour is unavailable if dc=-1 with j=0 and !avail[0], or dc=+1 with j=WIN_W-1 and !avail[1], or dr=-1 with i=0 and !avail[2], or dr=+1 with i=WIN_H-1 and !avail[3].
- pix_mask[p] = both neighbours available. If pix_mask[p]=0, edge_cat[p]=0. n_rec_l/n_rec_r still carry the raw window samples.
- Category: s = sign(cur-l)+sign(cur-r), with sign in {-1,0,+1}. Mapping: s=-2 gives 1, s=-1 gives 2, s=0 gives 0, s=+1 gives 3, s=+2 gives 4. Comparisons are unsigned, BIT_DEPTH wide.
- Stage 1 (S1): on in_valid&&in_ready, registers cur, l, r, and the per-pixel mask for the latched eo_type/avail.
- Stage 2 (S2): registers edge_cat, pix_mask and passes cur/l/r through. The outputs are S2 registers.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput: 1 beat/cycle.
- Handshake:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances into S2 when s1_valid && s2 advance.
  - in_ready = !s1_valid || s1 advance. This is combinational from out_ready; no bubble at full rate.
  - Data registers load only on advance.
  - While out_valid && !out_ready, every output is held stable.
- Simultaneous accept and drain in one cycle keeps both stages full with no loss or duplication.
- eo_type/avail are sampled only on accept. Changing them while stalled has no effect on in-flight beats.
- Reset (asynchronous, any time including mid-stall): s1_valid=s2_valid=0, so out_valid=0 and in_ready=1 after reset. All data outputs are 0 (edge_cat=0, pix_mask=0). In-flight beats are discarded.
- No combinational path from rec_in/eo_type/avail to any output.

Test Plan:
- Default params, EO_0, avail=4'hF, window row1={10,20,30,40}, row2={50,50,50,50}, out_ready=1 -> 2 cycles later n_rec_l={10,20,50,50}, n_rec_r={30,40,50,50}, edge_cat={0,0,0,0}, pix_mask=4'hF. Then change row1={30,10,30,0}, cur {10,30} -> cat {1,4}.
- EO_90, avail=4'b1011 (top missing) -> pixels 0,1 get pix_mask=0 and edge_cat=0; pixels 2,3 are categorised normally; n_rec_l[0]=rec(0,1).
- EO_45 vs EO_135 on a diagonal ramp rec(r,c)=16*r+4*c -> EO_135 cat 0 everywhere. Local min at rec(1,1)=0 with all neighbours 100 -> cat 1 for pixel 0 in every EO type.
- Back-pressure: 6 back-to-back beats, out_ready low for cycles 3-6 -> in_ready drops when both stages are full; outputs held stable; all 6 beats emerge in order, none duplicated.
- Reset asserted while both stages are full and stalled -> out_valid=0 and in_ready=1 immediately. The next accepted beat appears 2 cycles later.
- WIN_W=4, WIN_H=2, BIT_DEPTH=10, EO_0 with avail[1]=0 -> pixels 3,7 masked. Samples 1023 vs 0 give categories 4 and 1 correctly (no sign overflow).
